// File: rtl/nand_gate_checker.sv
// nand_gate_checker: drives the four {a,b} vectors into a NAND-built gate
// block, holds each vector for SETTLE_CYCLES cycles, samples the seven gate
// outputs once per vector against the ideal truth table, and reports
// pass/fail with per-vector and per-gate detail. All outputs are registered.
module nand_gate_checker #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       y_not,
   input  logic       y_and,
   input  logic       y_or,
   input  logic       y_nand,
   input  logic       y_nor,
   input  logic       y_xor,
   input  logic       y_xnor,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] vec_fail,
   output logic [6:0] err_mask
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Counter value on the last settle cycle of a vector.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   // Ideal gate outputs, packed in err_mask bit order (bit0 not .. bit6 xnor).
   function automatic logic [6:0] ideal_gates(input logic in_a, input logic in_b);
      ideal_gates = {~(in_a ^ in_b), in_a ^ in_b, ~(in_a | in_b),
                     ~(in_a & in_b), in_a | in_b, in_a & in_b, ~in_a};
   endfunction

   state_t     state_r,     state_s;
   logic [1:0] vec_r,       vec_s;
   logic [3:0] cnt_r,       cnt_s;
   logic       a_r,         a_s;
   logic       b_r,         b_s;
   logic       busy_r,      busy_s;
   logic       done_r,      done_s;
   logic       pass_r,      pass_s;
   logic [2:0] err_count_r, err_count_s;
   logic [3:0] vec_fail_r,  vec_fail_s;
   logic [6:0] err_mask_r,  err_mask_s;
   logic [6:0] observed_s;
   logic [6:0] mismatch_s;

   assign observed_s = {y_xnor, y_xor, y_nor, y_nand, y_or, y_and, y_not};
   assign mismatch_s = observed_s ^ ideal_gates(a_r, b_r);

   assign a         = a_r;
   assign b         = b_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign err_count = err_count_r;
   assign vec_fail  = vec_fail_r;
   assign err_mask  = err_mask_r;

   // Next-state and next-output logic; every register holds unless a state updates it.
   always_comb begin
      state_s     = state_r;
      vec_s       = vec_r;
      cnt_s       = cnt_r;
      a_s         = a_r;
      b_s         = b_r;
      pass_s      = pass_r;
      err_count_s = err_count_r;
      vec_fail_s  = vec_fail_r;
      err_mask_s  = err_mask_r;

      case (state_r)
         ST_IDLE: begin
            a_s = 1'b0;
            b_s = 1'b0;
            if (start) begin
               state_s     = ST_SETTLE;
               vec_s       = 2'd0;
               cnt_s       = 4'd0;
               pass_s      = 1'b0;
               err_count_s = 3'd0;
               vec_fail_s  = 4'd0;
               err_mask_s  = 7'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            cnt_s = cnt_r + 4'd1;
            if (cnt_r == SETTLE_LAST) begin
               state_s = ST_SAMPLE;
            end else begin
               state_s = ST_SETTLE;
            end
         end
         ST_SAMPLE: begin
            if (mismatch_s != 7'd0) begin
               vec_fail_s  = vec_fail_r | (4'b0001 << vec_r);
               err_count_s = err_count_r + 3'd1;
               err_mask_s  = err_mask_r | mismatch_s;
            end else begin
               vec_fail_s  = vec_fail_r;
            end
            if (vec_r == 2'd3) begin
               state_s = ST_DONE;
               pass_s  = (err_count_s == 3'd0);
            end else begin
               state_s    = ST_SETTLE;
               vec_s      = vec_r + 2'd1;
               cnt_s      = 4'd0;
               {a_s, b_s} = vec_r + 2'd1;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
            a_s     = 1'b0;
            b_s     = 1'b0;
         end
         default: begin
            state_s = ST_IDLE;
            a_s     = 1'b0;
            b_s     = 1'b0;
         end
      endcase

      busy_s = (state_s != ST_IDLE);
      done_s = (state_s == ST_DONE);
   end

   // State and output registers with synchronous reset clearing all results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         vec_r       <= 2'd0;
         cnt_r       <= 4'd0;
         a_r         <= 1'b0;
         b_r         <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         err_count_r <= 3'd0;
         vec_fail_r  <= 4'd0;
         err_mask_r  <= 7'd0;
      end else begin
         state_r     <= state_s;
         vec_r       <= vec_s;
         cnt_r       <= cnt_s;
         a_r         <= a_s;
         b_r         <= b_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         pass_r      <= pass_s;
         err_count_r <= err_count_s;
         vec_fail_r  <= vec_fail_s;
         err_mask_r  <= err_mask_s;
      end
   end

endmodule

// File: doc/nand_gate_checker.md
# nand_gate_checker

Self-checking response checker for the NAND-only basic-gate block (NOT, AND, OR, NAND, NOR, XOR, XNOR built from NAND). It drives the two gate inputs through all four combinations, waits a programmable settle time per vector, samples the seven gate outputs, and compares them against the ideal truth table. It reports a pass/fail verdict with per-gate and per-vector error detail. The DUT sits between its `a`/`b` outputs and its `y_*` inputs, so the gate block can be checked in hardware without a behavioural testbench.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `a`  out  1  gate input A (registered).
- `b`  out  1  gate input B (registered).
- `y_not`  in  1  DUT output; expected value ~a.
- `y_and`  in  1  DUT output; expected value a&b.
- `y_or`  in  1  DUT output; expected value a|b.
- `y_nand`  in  1  DUT output; expected value ~(a&b).
- `y_nor`  in  1  DUT output; expected value ~(a|b).
- `y_xor`  in  1  DUT output; expected value a^b.
- `y_xnor`  in  1  DUT output; expected value ~(a^b).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  set with `done`: 1 if no mismatch occurred; held until the next accepted start.
- `err_count`  out  3  number of failing vectors, 0..4.
- `vec_fail`  out  4  bit i set if vector i had any mismatch. Vector i is {a,b} = i.
- `err_mask`  out  7  sticky OR of per-gate mismatches: bit0 not, bit1 and, bit2 or, bit3 nand, bit4 nor, bit5 xor, bit6 xnor.

## Operation
- States:
  - IDLE: `a`=`b`=0. `start`=1 moves to SETTLE.
  - SETTLE: holds the current vector.
  - SAMPLE: compares the DUT outputs.
  - DONE: one cycle.
- Start acceptance (IDLE with `start`=1):
  - `vec`←0, settle counter←0.
  - `pass`, `err_count`, `vec_fail` and `err_mask` all clear to 0.
  - `a`←0, `b`←0.
- SETTLE:
  - `a`=vec[1], `b`=vec[0].
  - The counter increments each cycle. After `SETTLE_CYCLES` cycles in SETTLE, go to SAMPLE.
- SAMPLE:
  - Compute the expected 7-bit vector from the current `a`/`b`, then XOR it with the `y_*` inputs.
  - Any nonzero bit: set `vec_fail[vec]`, increment `err_count`, and OR the bits into `err_mask`.
  - If `vec`==3, go to DONE.
  - Otherwise `vec`←`vec`+1, counter←0, update `a`/`b` to the new vector, and go to SETTLE.
- DONE:
  - `done`=1 and `pass`←(`err_count`==0 including this run's last sample).
  - Return to IDLE. `a`/`b` return to 0 in IDLE.
- `start` in SETTLE, SAMPLE or DONE is ignored, not queued.
- With `start` held high continuously, back-to-back runs occur, each separated by one IDLE cycle.
- `err_count` cannot overflow: at most 4 vectors can fail.
- Results stay stable from DONE until the next accepted start.

## Timing
- Reset: a synchronous `rst` forces IDLE on the next edge. Reset values:
  - `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `vec_fail`=0, `err_mask`=0.
- `rst` mid-run: abort on the next edge. No `done` pulse; all results cleared. `rst` has priority over `start`.
- Let start be accepted at edge E0. With S = `SETTLE_CYCLES`:
  - Vector i is driven from edge E0+i(S+1).
  - Vector i is sampled in the cycle after edge E0+i(S+1)+S.
  - `done` is high in the cycle after edge E0+4(S+1).
- Total run latency: 4(S+1)+1 cycles from start acceptance to IDLE. For S=2: `done` follows edge E0+12; IDLE resumes at E0+13.
- DUT inputs are compared combinationally in the SAMPLE cycle only. Values during SETTLE are never checked, so glitches there are tolerated.

## Test plan
- Reset: hold `rst` for 2 cycles while `start`=1. Required: all outputs 0, no run starts, `busy`=0.
- Golden DUT, S=2, 1-cycle `start` pulse. Required:
  - `a`/`b` sequence 00, 01, 10, 11, each held 3 cycles.
  - `done` pulse exactly 12 cycles after acceptance.
  - `pass`=1, `err_count`=0, `vec_fail`=4'b0000, `err_mask`=7'b0000000.
- `y_xor` stuck at 0. Required: `vec_fail`=4'b0110, `err_count`=2, `err_mask`=7'b0100000, `pass`=0.
- `y_not` tied to `b`. Required: `vec_fail`=4'b1001, `err_count`=2, `err_mask`=7'b0000001, `pass`=0.
- `start` pulsed again mid-run. Required: ignored, single `done`.
- `start` held high. Required: second run begins after one IDLE cycle, and results from the first run are cleared at that acceptance.
- `rst` asserted while vector 2 is being driven. Required: IDLE next cycle, no `done`, all outputs 0. A subsequent start with a golden DUT gives `pass`=1.
